branch_predictor: RTL and testbench
===================================

# branch_predictor

- Fetch-stage dynamic branch predictor.
- Produces the `predict` bit and predicted target that travel down the pipeline with each instruction.
- Is trained by the execute stage once a control-transfer instruction resolves.
- Implements a direct-mapped, tagged branch target buffer with a 2-bit saturating counter per entry; lookup is combinational against the current fetch PC.

## Interface
Parameters:
- IDX_W, 6, index width; table depth = 2**IDX_W entries
- TAG_W, 8, tag width stored per entry

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pc_f  in  32  fetch PC to look up
- predict_f  out  1  1 = predicted taken
- pred_target_f  out  32  predicted target; 0 when predict_f = 0
- upd_en  in  1  execute-stage training strobe, one per resolved control instruction
- upd_pc  in  32  PC of the resolved instruction
- upd_is_br  in  1  1 = conditional branch, 0 = unconditional jump
- upd_taken  in  1  resolved direction
- upd_target  in  32  resolved target address
- upd_mispred  in  1  execute-stage mispredict flag, valid with upd_en
- mispred_cnt  out  16  saturating count of mispredicts

## Operation
Address fields:
- index = pc[IDX_W+1:2]
- tag = pc[IDX_W+TAG_W+1:IDX_W+2]
- pc[1:0] is ignored.

Entry contents: valid (1 bit), tag (TAG_W bits), target (32 bits), ctr (2 bits).
- ctr encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.

Lookup:
- hit = valid[index] & (tag[index] == tag(pc_f)).
- predict_f = hit & ctr[index][1].
- pred_target_f = target[index] when predict_f = 1, else 0.

Training, applied at the rising edge when upd_en = 1:
- Miss (invalid entry, or tag mismatch):
  - Allocate the entry: valid = 1, tag and target loaded.
  - ctr = 10 if upd_taken, else 01.
  - Jumps (upd_is_br = 0) are always allocated with ctr = 11.
- Hit, conditional branch:
  - ctr increments if taken, decrements if not taken, saturating at 11 and 00.
  - target is overwritten only when upd_taken = 1.
- Hit, jump: ctr = 11 and target is overwritten.
- Not-taken branch that misses: the entry is still allocated (ctr = 01), so any aliased entry is evicted.

Mispredict counter:
- mispred_cnt increments by 1 when upd_en & upd_mispred.
- Saturates at 16'hFFFF.
- upd_mispred is ignored when upd_en = 0.

Other rules:
- upd_en = 0: table and counter hold.
- Upstream stall or flush has no effect on the predictor; the caller handles it by not pulsing upd_en.

## Timing
Reset (rst_n low, asynchronous, any time including mid-update):
- All valid bits = 0.
- All ctr = 01, all tags = 0, all targets = 0.
- mispred_cnt = 0.
- Therefore predict_f = 0 and pred_target_f = 0 in the same cycle reset asserts.
- Reset release is used synchronously by the caller; the first training edge is the first rising clk edge with rst_n high.

Latency:
- Lookup is 0-cycle (combinational from pc_f and table state).
- A training update becomes visible to lookup in the cycle after the update edge.

Same-index read/write collision: a lookup in the same cycle as an update to that index returns the pre-update entry. There is no write-to-read bypass.

Per-edge limits: at most one table write and one counter increment per edge.

## Test plan
1. Reset: assert rst_n = 0 mid-cycle after several updates.
   - Required: predict_f = 0, pred_target_f = 0, mispred_cnt = 0 immediately, with no clock edge.
2. Allocate and hit:
   - Update pc = 0x0000_0040, branch, taken, target 0x0000_0100.
   - Next cycle, pc_f = 0x40 gives predict_f = 1 and pred_target_f = 0x100.
   - pc_f = 0x0000_4040 (same index, different tag) gives predict_f = 0.
3. Saturation:
   - Three taken updates, then a lookup at 0x40: predict_f = 1.
   - Then one not-taken: predict_f = 1 (ctr 10).
   - Then a second not-taken: predict_f = 0 (ctr 01).
   - Six not-taken total: ctr stays at 00.
4. Jump:
   - Update pc = 0x80, upd_is_br = 0, target 0x200, upd_taken = 1.
   - Required: predict_f = 1, pred_target_f = 0x200.
   - One not-taken branch update to 0x80 leaves predict_f = 1 (ctr 11 → 10).
5. Collision:
   - pc_f = 0x40 while updating 0x40 from ctr 01 to taken.
   - Required: that cycle predict_f = 0; next cycle predict_f = 1.
6. Mispredict counter:
   - 5 upd_en pulses with upd_mispred = 1 plus 3 cycles with upd_mispred = 1 but upd_en = 0 give mispred_cnt = 5.
   - Preloading near saturation and pulsing beyond it holds mispred_cnt at 0xFFFF.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped tagged BTB with 2-bit counters.
// Combinational lookup on pc_f; trained by the execute stage via upd_*.
module branch_predictor #(
   parameter int IDX_W = 6,
   parameter int TAG_W = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_f,
   output logic        predict_f,
   output logic [31:0] pred_target_f,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic        upd_is_br,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_mispred,
   output logic [15:0] mispred_cnt
);

   localparam int DEPTH = 1 << IDX_W;
   localparam int TLO   = IDX_W + 2;
   localparam int THI   = IDX_W + TAG_W + 1;

   logic             valid_q  [DEPTH];
   logic [TAG_W-1:0] tag_q    [DEPTH];
   logic [31:0]      target_q [DEPTH];
   logic [1:0]       ctr_q    [DEPTH];
   logic [15:0]      cnt_q;

   logic [IDX_W-1:0] f_idx;
   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] f_tag;
   logic [TAG_W-1:0] u_tag;
   logic             f_hit;
   logic             u_hit;
   logic [1:0]       u_ctr;
   logic [1:0]       ctr_nxt;
   logic [31:0]      tgt_nxt;

   // PC bits outside the index/tag fields play no part in the lookup
   logic unused_bits;
   assign unused_bits = ^{pc_f[31:THI+1], pc_f[1:0],
                          upd_pc[31:THI+1], upd_pc[1:0]};

   assign f_idx = pc_f[TLO-1:2];
   assign f_tag = pc_f[THI:TLO];
   assign u_idx = upd_pc[TLO-1:2];
   assign u_tag = upd_pc[THI:TLO];

   assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
   assign u_ctr = ctr_q[u_idx];

   assign predict_f     = f_hit & ctr_q[f_idx][1];
   assign pred_target_f = predict_f ? target_q[f_idx] : 32'h0;
   assign mispred_cnt   = cnt_q;

   // Next counter/target for the entry being trained
   always_comb begin
      ctr_nxt = u_ctr;
      tgt_nxt = target_q[u_idx];
      unique case (1'b1)
         !u_hit: begin
            tgt_nxt = upd_target;
            if (!upd_is_br)     ctr_nxt = 2'b11;
            else if (upd_taken) ctr_nxt = 2'b10;
            else                ctr_nxt = 2'b01;
         end
         u_hit && !upd_is_br: begin
            ctr_nxt = 2'b11;
            tgt_nxt = upd_target;
         end
         u_hit && upd_is_br && upd_taken: begin
            ctr_nxt = (u_ctr == 2'b11) ? 2'b11 : u_ctr + 2'd1;
            tgt_nxt = upd_target;
         end
         u_hit && upd_is_br && !upd_taken: begin
            ctr_nxt = (u_ctr == 2'b00) ? 2'b00 : u_ctr - 2'd1;
         end
         default: begin
            ctr_nxt = u_ctr;
         end
      endcase
   end

   // Table write: one entry per training strobe, allocate on miss
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
      end else if (upd_en) begin
         valid_q[u_idx]  <= 1'b1;
         tag_q[u_idx]    <= u_tag;
         target_q[u_idx] <= tgt_nxt;
         ctr_q[u_idx]    <= ctr_nxt;
      end
   end

   // Saturating mispredict counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (upd_en && upd_mispred && (cnt_q != 16'hFFFF)) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus
// randomized training checked against an entry-level reference model.
module tb_branch_predictor;

   localparam int DEPTH = 64;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc_f;
   logic        predict_f;
   logic [31:0] pred_target_f;
   logic        upd_en;
   logic [31:0] upd_pc;
   logic        upd_is_br;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_mispred;
   logic [15:0] mispred_cnt;

   int total = 0;
   int bad   = 0;

   bit          m_valid [DEPTH];
   int          m_tag   [DEPTH];
   logic [31:0] m_tgt   [DEPTH];
   int          m_ctr   [DEPTH];
   int          m_cnt;

   branch_predictor #(.IDX_W(6), .TAG_W(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pc_f          (pc_f),
      .predict_f     (predict_f),
      .pred_target_f (pred_target_f),
      .upd_en        (upd_en),
      .upd_pc        (upd_pc),
      .upd_is_br     (upd_is_br),
      .upd_taken     (upd_taken),
      .upd_target    (upd_target),
      .upd_mispred   (upd_mispred),
      .mispred_cnt   (mispred_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = 0;
         m_tgt[i]   = 32'h0;
         m_ctr[i]   = 1;
      end
      m_cnt = 0;
   endfunction

   function automatic int idx_of(input logic [31:0] pc);
      return int'(pc[7:2]);
   endfunction

   function automatic int tag_of(input logic [31:0] pc);
      return int'(pc[15:8]);
   endfunction

   function automatic bit m_pred(input logic [31:0] pc);
      int i;
      i = idx_of(pc);
      return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
   endfunction

   function automatic logic [31:0] m_target(input logic [31:0] pc);
      return m_pred(pc) ? m_tgt[idx_of(pc)] : 32'h0;
   endfunction

   function automatic void model_train(input logic [31:0] pc, input bit br,
                                       input bit tk, input logic [31:0] tgt,
                                       input bit mis);
      int i;
      i = idx_of(pc);
      if (!(m_valid[i] && m_tag[i] == tag_of(pc))) begin
         m_valid[i] = 1'b1;
         m_tag[i]   = tag_of(pc);
         m_tgt[i]   = tgt;
         m_ctr[i]   = !br ? 3 : (tk ? 2 : 1);
      end else if (!br) begin
         m_ctr[i] = 3;
         m_tgt[i] = tgt;
      end else if (tk) begin
         m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
         m_tgt[i] = tgt;
      end else begin
         m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
      if (mis) m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
   endfunction

   function automatic logic [31:0] rand_pc();
      logic [31:0] p;
      p = $urandom;
      p[15:8] = 8'($urandom_range(0, 2));
      p[7:2]  = 6'($urandom_range(0, 7));
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_update(input logic [31:0] pc, input bit br, input bit tk,
                            input logic [31:0] tgt, input bit mis);
      upd_en      = 1'b1;
      upd_pc      = pc;
      upd_is_br   = br;
      upd_taken   = tk;
      upd_target  = tgt;
      upd_mispred = mis;
      tick();
      model_train(pc, br, tk, tgt, mis);
      upd_en      = 1'b0;
      upd_mispred = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      upd_en = 1'b0; upd_pc = '0; upd_is_br = 1'b0; upd_taken = 1'b0;
      upd_target = '0; upd_mispred = 1'b0;
      pc_f = 32'h40;
      model_reset();
      #1;
      total++;
      if (predict_f !== 1'b0) begin
         bad++; $display("FAIL reset_predict: got %0b want 0", predict_f);
      end
      total++;
      if (pred_target_f !== 32'h0) begin
         bad++; $display("FAIL reset_target: got %0h want 0", pred_target_f);
      end
      total++;
      if (mispred_cnt !== 16'h0) begin
         bad++; $display("FAIL reset_cnt: got %0h want 0", mispred_cnt);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_alloc_hit();
      do_update(32'h40, 1'b1, 1'b1, 32'h100, 1'b0);
      pc_f = 32'h40;
      #1;
      total++;
      if (predict_f !== 1'b1 || pred_target_f !== 32'h100) begin
         bad++;
         $display("FAIL alloc_hit: got %0b/%0h want 1/100", predict_f, pred_target_f);
      end
      pc_f = 32'h4040;
      #1;
      total++;
      if (predict_f !== 1'b0 || pred_target_f !== 32'h0) begin
         bad++;
         $display("FAIL tag_miss: got %0b/%0h want 0/0", predict_f, pred_target_f);
      end
   endtask

   task automatic test_saturation();
      pc_f = 32'h40;
      repeat (3) do_update(32'h40, 1'b1, 1'b1, 32'h100, 1'b0);
      #1;
      total++;
      if (predict_f !== 1'b1) begin
         bad++; $display("FAIL sat_taken: got %0b want 1", predict_f);
      end
      do_update(32'h40, 1'b1, 1'b0, 32'hDEAD0, 1'b0);
      total++;
      if (predict_f !== 1'b1 || pred_target_f !== 32'h100) begin
         bad++;
         $display("FAIL sat_nt1: got %0b/%0h want 1/100", predict_f, pred_target_f);
      end
      do_update(32'h40, 1'b1, 1'b0, 32'hDEAD0, 1'b0);
      total++;
      if (predict_f !== 1'b0) begin
         bad++; $display("FAIL sat_nt2: got %0b want 0", predict_f);
      end
      repeat (4) do_update(32'h40, 1'b1, 1'b0, 32'hDEAD0, 1'b0);
      do_update(32'h40, 1'b1, 1'b1, 32'h104, 1'b0);
      total++;
      if (predict_f !== 1'b0) begin
         bad++; $display("FAIL sat_floor: got %0b want 0", predict_f);
      end
      do_update(32'h40, 1'b1, 1'b1, 32'h108, 1'b0);
      total++;
      if (predict_f !== 1'b1 || pred_target_f !== 32'h108) begin
         bad++;
         $display("FAIL sat_climb: got %0b/%0h want 1/108", predict_f, pred_target_f);
      end
   endtask

   task automatic test_jump();
      pc_f = 32'h80;
      do_update(32'h80, 1'b0, 1'b1, 32'h200, 1'b0);
      total++;
      if (predict_f !== 1'b1 || pred_target_f !== 32'h200) begin
         bad++;
         $display("FAIL jump_alloc: got %0b/%0h want 1/200", predict_f, pred_target_f);
      end
      do_update(32'h80, 1'b1, 1'b0, 32'h300, 1'b0);
      total++;
      if (predict_f !== 1'b1 || pred_target_f !== 32'h200) begin
         bad++;
         $display("FAIL jump_nt: got %0b/%0h want 1/200", predict_f, pred_target_f);
      end
   endtask

   task automatic test_collision();
      do_update(32'h4040, 1'b1, 1'b0, 32'h500, 1'b0);
      pc_f = 32'h40;
      #1;
      total++;
      if (predict_f !== 1'b0) begin
         bad++; $display("FAIL evict: got %0b want 0", predict_f);
      end
      pc_f        = 32'h4040;
      upd_en      = 1'b1;
      upd_pc      = 32'h4040;
      upd_is_br   = 1'b1;
      upd_taken   = 1'b1;
      upd_target  = 32'h500;
      upd_mispred = 1'b0;
      #1;
      total++;
      if (predict_f !== 1'b0) begin
         bad++; $display("FAIL collide_same: got %0b want 0", predict_f);
      end
      tick();
      model_train(32'h4040, 1'b1, 1'b1, 32'h500, 1'b0);
      upd_en = 1'b0;
      #1;
      total++;
      if (predict_f !== 1'b1 || pred_target_f !== 32'h500) begin
         bad++;
         $display("FAIL collide_next: got %0b/%0h want 1/500", predict_f, pred_target_f);
      end
   endtask

   task automatic test_mispred_cnt();
      for (int k = 0; k < 5; k++)
         do_update(32'hC0 + 32'(k * 4), 1'b1, 1'b1, 32'h600, 1'b1);
      upd_mispred = 1'b1;
      upd_en      = 1'b0;
      repeat (3) tick();
      upd_mispred = 1'b0;
      total++;
      if (mispred_cnt !== 16'd5) begin
         bad++; $display("FAIL cnt_five: got %0d want 5", mispred_cnt);
      end
   endtask

   task automatic test_random();
      bit en;
      for (int n = 0; n < 600; n++) begin
         en          = ($urandom_range(0, 3) != 0);
         pc_f        = rand_pc();
         upd_en      = en;
         upd_pc      = rand_pc();
         upd_is_br   = ($urandom_range(0, 4) != 0);
         upd_taken   = $urandom_range(0, 1) == 1;
         upd_target  = $urandom & 32'hFFFF_FFFC;
         upd_mispred = $urandom_range(0, 1) == 1;
         #1;
         total++;
         if (predict_f !== m_pred(pc_f)) begin
            bad++;
            $display("FAIL rnd_predict pc=%0h: got %0b want %0b",
                     pc_f, predict_f, m_pred(pc_f));
         end
         total++;
         if (pred_target_f !== m_target(pc_f)) begin
            bad++;
            $display("FAIL rnd_target pc=%0h: got %0h want %0h",
                     pc_f, pred_target_f, m_target(pc_f));
         end
         tick();
         if (en)
            model_train(upd_pc, upd_is_br, upd_taken, upd_target, upd_mispred);
         total++;
         if (mispred_cnt !== 16'(m_cnt)) begin
            bad++;
            $display("FAIL rnd_cnt: got %0d want %0d", mispred_cnt, m_cnt);
         end
      end
      upd_en      = 1'b0;
      upd_mispred = 1'b0;
   endtask

   task automatic test_cnt_saturation();
      upd_en      = 1'b1;
      upd_mispred = 1'b1;
      upd_pc      = 32'h1000;
      upd_is_br   = 1'b1;
      upd_taken   = 1'b1;
      upd_target  = 32'h700;
      for (int n = 0; n < 65540; n++) begin
         tick();
         model_train(upd_pc, 1'b1, 1'b1, 32'h700, 1'b1);
      end
      total++;
      if (mispred_cnt !== 16'hFFFF) begin
         bad++; $display("FAIL cnt_sat: got %0h want ffff", mispred_cnt);
      end
      tick();
      upd_en      = 1'b0;
      upd_mispred = 1'b0;
      total++;
      if (mispred_cnt !== 16'hFFFF) begin
         bad++; $display("FAIL cnt_hold: got %0h want ffff", mispred_cnt);
      end
   endtask

   task automatic test_async_reset();
      pc_f = 32'h80;
      do_update(32'h88, 1'b0, 1'b1, 32'h800, 1'b1);
      do_update(32'h8C, 1'b1, 1'b1, 32'h900, 1'b1);
      total++;
      if (predict_f !== 1'b1 || pred_target_f !== 32'h200) begin
         bad++;
         $display("FAIL pre_reset: got %0b/%0h want 1/200", predict_f, pred_target_f);
      end
      upd_en      = 1'b1;
      upd_pc      = 32'h80;
      upd_is_br   = 1'b0;
      upd_target  = 32'hA00;
      upd_mispred = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (predict_f !== 1'b0 || pred_target_f !== 32'h0) begin
         bad++;
         $display("FAIL async_pred: got %0b/%0h want 0/0", predict_f, pred_target_f);
      end
      total++;
      if (mispred_cnt !== 16'h0) begin
         bad++; $display("FAIL async_cnt: got %0h want 0", mispred_cnt);
      end
      upd_en      = 1'b0;
      upd_mispred = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      total++;
      if (predict_f !== 1'b0 || mispred_cnt !== 16'h0) begin
         bad++;
         $display("FAIL post_reset: got %0b/%0h want 0/0", predict_f, mispred_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_alloc_hit();
      test_saturation();
      test_jump();
      test_collision();
      test_mispred_cnt();
      test_random();
      test_cnt_saturation();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
